// File: rtl/sprite_anim_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_anim_renderer_if
//  Brief    : Sprite ROM and palette lookup bus between renderer and memories.
//  Revision : 1.0
// ============================================================================
interface sprite_anim_renderer_if #(
    parameter int ADDR_W = 11,
    parameter int IDX_W  = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_q;
    logic [IDX_W-1:0]  pal_idx;
    logic [3:0]        pal_red;
    logic [3:0]        pal_green;
    logic [3:0]        pal_blue;

    modport master (
        output rom_addr,
        output pal_idx,
        input  rom_q,
        input  pal_red,
        input  pal_green,
        input  pal_blue
    );

    modport slave (
        input  rom_addr,
        input  pal_idx,
        output rom_q,
        output pal_red,
        output pal_green,
        output pal_blue
    );
endinterface
`default_nettype wire

// File: rtl/sprite_anim_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_anim_renderer
//  Brief    : Pipelined animated sprite renderer with colour-key transparency.
//             Define SPRITE_FLIP_EN to build the horizontal mirror.
//  Revision : 1.0
// ============================================================================
module sprite_anim_renderer #(
    parameter int SPR_W      = 20,
    parameter int SPR_H      = 20,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 8,
    parameter int ADDR_W     = 11,
    parameter int IDX_W      = 8,
    parameter int TRANSP_IDX = 0
) (
    input  wire logic       vga_clk,
    input  wire logic       Reset,
    input  wire logic [9:0] DrawX,
    input  wire logic [9:0] DrawY,
    input  wire logic [9:0] SpriteX,
    input  wire logic [9:0] SpriteY,
    input  wire logic       blank,
    input  wire logic       frame_tick,
    input  wire logic       anim_en,
    input  wire logic       anim_restart,
    input  wire logic       flip,
    sprite_anim_renderer_if.master mem,
    output logic [3:0]      red,
    output logic [3:0]      green,
    output logic [3:0]      blue,
    output logic            sprite_on,
    output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] frame_idx
);

    localparam int c_FRAME_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int c_HOLD_W    = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int c_FRAME_PIX = SPR_W * SPR_H;

    logic [c_FRAME_W-1:0] r_frame;
    logic [c_HOLD_W-1:0]  r_hold;
    logic                 r_hit_d1;
    logic                 r_blank_d1;
    logic [3:0]           r_red;
    logic [3:0]           r_green;
    logic [3:0]           r_blue;
    logic                 r_on;

    logic [10:0]          w_x;
    logic [10:0]          w_y;
    logic [10:0]          w_x0;
    logic [10:0]          w_y0;
    logic                 w_hit;
    logic [9:0]           w_dx;
    logic [9:0]           w_dy;
    logic [9:0]           w_dxf;
    logic [ADDR_W-1:0]    w_addr;
    logic                 w_opaque;

    // Eleven-bit compare keeps a box near the right/bottom edge from wrapping.
    assign w_x   = {1'b0, DrawX};
    assign w_y   = {1'b0, DrawY};
    assign w_x0  = {1'b0, SpriteX};
    assign w_y0  = {1'b0, SpriteY};
    assign w_hit = (w_x >= w_x0) && (w_x < w_x0 + 11'(SPR_W)) &&
                   (w_y >= w_y0) && (w_y < w_y0 + 11'(SPR_H));

    assign w_dx = DrawX - SpriteX;
    assign w_dy = DrawY - SpriteY;

`ifdef SPRITE_FLIP_EN
    assign w_dxf = flip ? (10'(SPR_W - 1) - w_dx) : w_dx;
`else
    logic w_unused_flip;
    assign w_unused_flip = flip;
    assign w_dxf         = w_dx;
`endif

    assign w_addr = ADDR_W'(r_frame) * ADDR_W'(c_FRAME_PIX)
                  + ADDR_W'(w_dy) * ADDR_W'(SPR_W)
                  + ADDR_W'(w_dxf);

    assign mem.rom_addr = w_hit ? w_addr : '0;
    assign mem.pal_idx  = mem.rom_q;

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_frame <= '0;
            r_hold  <= '0;
        end else if (anim_restart) begin
            r_frame <= '0;
            r_hold  <= '0;
        end else if (frame_tick && anim_en) begin
            if (r_hold == c_HOLD_W'(FRAME_HOLD - 1)) begin
                r_hold <= '0;
                if (r_frame == c_FRAME_W'(NUM_FRAMES - 1)) begin
                    r_frame <= '0;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    // Stage 1 qualifiers line up with rom_q, which arrives one edge after rom_addr.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_hit_d1   <= 1'b0;
            r_blank_d1 <= 1'b0;
        end else begin
            r_hit_d1   <= w_hit;
            r_blank_d1 <= blank;
        end
    end

    assign w_opaque = r_blank_d1 && r_hit_d1 && (mem.rom_q != IDX_W'(TRANSP_IDX));

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_red   <= 4'h0;
            r_green <= 4'h0;
            r_blue  <= 4'h0;
            r_on    <= 1'b0;
        end else if (w_opaque) begin
            r_red   <= mem.pal_red;
            r_green <= mem.pal_green;
            r_blue  <= mem.pal_blue;
            r_on    <= 1'b1;
        end else begin
            r_red   <= 4'h0;
            r_green <= 4'h0;
            r_blue  <= 4'h0;
            r_on    <= 1'b0;
        end
    end

    assign red       = r_red;
    assign green     = r_green;
    assign blue      = r_blue;
    assign sprite_on = r_on;
    assign frame_idx = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_anim_renderer
//  Brief    : Directed bench for sprite_anim_renderer with a reference model.
//  Revision : 1.0
// ============================================================================
module tb_sprite_anim_renderer;

    logic       vga_clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY, SpriteX, SpriteY;
    logic       blank, frame_tick, anim_en, anim_restart, flip;
    logic [3:0] red, green, blue;
    logic       sprite_on;
    logic [1:0] frame_idx;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [7:0] rom [0:2047];

    sprite_anim_renderer_if #(.ADDR_W(11), .IDX_W(8)) mem_if ();

    sprite_anim_renderer dut (
        .vga_clk      (vga_clk),
        .Reset        (Reset),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .SpriteX      (SpriteX),
        .SpriteY      (SpriteY),
        .blank        (blank),
        .frame_tick   (frame_tick),
        .anim_en      (anim_en),
        .anim_restart (anim_restart),
        .flip         (flip),
        .mem          (mem_if),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .sprite_on    (sprite_on),
        .frame_idx    (frame_idx)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [11:0] pal_of(input logic [7:0] idx);
        if (idx == 8'd5) return 12'hF82;
        return {idx[3:0], ~idx[3:0], idx[7:4]};
    endfunction

    // Synchronous ROM and combinational palette owned by the bench
    always @(posedge vga_clk) mem_if.rom_q <= rom[mem_if.rom_addr];
    always_comb {mem_if.pal_red, mem_if.pal_green, mem_if.pal_blue} = pal_of(mem_if.pal_idx);

    // ---------------- reference model ----------------
    int         m_ticks = 0;
    bit         s1_vis  = 1'b0;
    int         s1_addr = 0;
    bit         e_on    = 1'b0;
    logic [11:0] e_rgb  = 12'h0;

    function automatic int m_frame();
        return (m_ticks / 8) % 4;
    endfunction

    function automatic bit m_hit();
        int x, y, sx, sy;
        x = int'(DrawX); y = int'(DrawY); sx = int'(SpriteX); sy = int'(SpriteY);
        return (x >= sx) && (x < sx + 20) && (y >= sy) && (y < sy + 20);
    endfunction

    function automatic int m_addr();
        int dx, dy;
        if (!m_hit()) return 0;
        dx = int'(DrawX) - int'(SpriteX);
        dy = int'(DrawY) - int'(SpriteY);
`ifdef SPRITE_FLIP_EN
        if (flip) dx = 19 - dx;
`endif
        return (m_frame() * 400 + dy * 20 + dx) % 2048;
    endfunction

    always @(posedge vga_clk) begin
        if (Reset) begin
            m_ticks <= 0;
            s1_vis  <= 1'b0;
            s1_addr <= 0;
            e_on    <= 1'b0;
            e_rgb   <= 12'h0;
        end else begin
            if (anim_restart)                m_ticks <= 0;
            else if (frame_tick && anim_en)  m_ticks <= m_ticks + 1;
            s1_vis  <= m_hit() && blank;
            s1_addr <= m_addr();
            if (s1_vis && rom[s1_addr] != 8'd0) begin
                e_on  <= 1'b1;
                e_rgb <= pal_of(rom[s1_addr]);
            end else begin
                e_on  <= 1'b0;
                e_rgb <= 12'h0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge vga_clk) begin
        if (chk_en) begin
            chk("model rom_addr", int'(mem_if.rom_addr), m_addr());
            chk("model frame_idx", int'(frame_idx), m_frame());
            chk("model sprite_on", int'(sprite_on), int'(e_on));
            chk("model rgb", int'({red, green, blue}), int'(e_rgb));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    initial begin
        for (int a = 0; a < 2048; a++)
            rom[a] = (a % 6 == 3) ? 8'd0 : 8'((a * 7 + 5) % 256);

        Reset = 1'b1; DrawX = 10'd0; DrawY = 10'd0; SpriteX = 10'd100; SpriteY = 10'd50;
        blank = 1'b0; frame_tick = 1'b0; anim_en = 1'b0; anim_restart = 1'b0; flip = 1'b0;
        repeat (3) cyc();
        @(negedge vga_clk);
        chk("reset sprite_on", int'(sprite_on), 0);
        chk("reset rgb", int'({red, green, blue}), 0);
        chk("reset frame_idx", int'(frame_idx), 0);
        chk_en = 1'b1;
        cyc();
        Reset = 1'b0;

        // Row sweep across the box; outputs trail the pixel by two edges
        DrawY = 10'd50; blank = 1'b1;
        for (int x = 98; x <= 122; x++) begin
            DrawX = 10'(x);
            @(negedge vga_clk);
            if (x == 99)  chk("sweep addr x99", int'(mem_if.rom_addr), 0);
            if (x == 100) chk("sweep addr x100", int'(mem_if.rom_addr), 0);
            if (x == 119) chk("sweep addr x119", int'(mem_if.rom_addr), 19);
            if (x == 120) chk("sweep addr x120", int'(mem_if.rom_addr), 0);
            if (x == 101) chk("latency pix99 on", int'(sprite_on), 0);
            if (x == 102) begin
                chk("latency pix100 on", int'(sprite_on), 1);
                chk("pix100 rgb F82", int'({red, green, blue}), 'hF82);
            end
            if (x == 105) chk("transparent pix103", int'(sprite_on), 0);
            cyc();
        end

        // Active-video gate
        DrawX = 10'd100; blank = 1'b0;
        cyc(); cyc();
        @(negedge vga_clk);
        chk("blank0 sprite_on", int'(sprite_on), 0);
        chk("blank0 rgb", int'({red, green, blue}), 0);
        cyc();
        blank = 1'b1;

        // Right screen edge
        SpriteX = 10'd630;
        for (int x = 628; x <= 639; x++) begin
            DrawX = 10'(x);
            @(negedge vga_clk);
            if (x == 629) chk("edge addr x629", int'(mem_if.rom_addr), 0);
            if (x == 630) chk("edge addr x630", int'(mem_if.rom_addr), 0);
            if (x == 639) chk("edge addr x639", int'(mem_if.rom_addr), 9);
            if (x == 632) chk("edge pix630 on", int'(sprite_on), 1);
            cyc();
        end

        // Box extending past 1023 must not wrap onto the left of the screen
        SpriteX = 10'd1010; DrawX = 10'd5;
        @(negedge vga_clk);
        chk("nowrap addr", int'(mem_if.rom_addr), 0);
        cyc(); cyc();
        @(negedge vga_clk);
        chk("nowrap sprite_on", int'(sprite_on), 0);
        cyc();

        // Animation stepping
        SpriteX = 10'd100; DrawX = 10'd0; anim_en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 7)  chk("anim tick7", int'(frame_idx), 0);
            if (k == 8)  chk("anim tick8", int'(frame_idx), 1);
            if (k == 16) begin
                chk("anim tick16", int'(frame_idx), 2);
                DrawX = 10'd100;
                @(negedge vga_clk);
                chk("frame2 base addr", int'(mem_if.rom_addr), 800);
                cyc();
                DrawX = 10'd0;
            end
            if (k == 24) chk("anim tick24", int'(frame_idx), 3);
            if (k == 32) chk("anim tick32", int'(frame_idx), 0);
        end

        // Restart against a simultaneous tick
        repeat (31) tick();
        chk("frame3 hold7", int'(frame_idx), 3);
        frame_tick = 1'b1; anim_restart = 1'b1;
        cyc();
        frame_tick = 1'b0; anim_restart = 1'b0;
        chk("restart at f3h7", int'(frame_idx), 0);
        repeat (8) tick();
        chk("after restart 8 ticks", int'(frame_idx), 1);
        frame_tick = 1'b1; anim_restart = 1'b1;
        cyc();
        frame_tick = 1'b0; anim_restart = 1'b0;
        repeat (7) tick();
        chk("restart clears hold", int'(frame_idx), 0);
        tick();
        chk("restart hold wrap", int'(frame_idx), 1);

        anim_en = 1'b0;
        repeat (10) tick();
        chk("anim_en0 holds", int'(frame_idx), 1);

        // Reset in the middle of a visible run
        DrawX = 10'd100; DrawY = 10'd50;
        cyc(); cyc();
        @(negedge vga_clk);
        chk("pre-reset on", int'(sprite_on), 1);
        cyc();
        Reset = 1'b1;
        cyc();
        @(negedge vga_clk);
        chk("midline reset on", int'(sprite_on), 0);
        chk("midline reset rgb", int'({red, green, blue}), 0);
        chk("midline reset frame", int'(frame_idx), 0);
        cyc();
        Reset = 1'b0;

        // Horizontal mirror
        flip = 1'b1;
        @(negedge vga_clk);
`ifdef SPRITE_FLIP_EN
        chk("flip addr", int'(mem_if.rom_addr), 19);
`else
        chk("flip ignored addr", int'(mem_if.rom_addr), 0);
`endif
        cyc();
        flip = 1'b0;
        repeat (4) cyc();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_anim_renderer.md
# sprite_anim_renderer

Parametrised, pipelined sprite renderer for the VGA path. For every pixel it checks whether (DrawX, DrawY) lies inside a SPR_W×SPR_H box placed at (SpriteX, SpriteY). It then reads the pixel's palette index from an external synchronous sprite ROM and resolves it through an external palette. Outputs are registered 4-bit RGB plus an opaque-hit flag. Beyond the single-frame fixed-size renderer, it adds a configurable box size, multi-frame animation driven by a per-frame tick, a transparent colour key and optional horizontal mirroring. It sits between the VGA controller and the screen compositor, one instance per sprite.

## Interface
Parameters
- SPR_W, 20, sprite width in pixels
- SPR_H, 20, sprite height in pixels
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM
- FRAME_HOLD, 8, frame_tick pulses per animation frame (≥1)
- ADDR_W, 11, ROM address width; must satisfy 2^ADDR_W ≥ SPR_W·SPR_H·NUM_FRAMES
- IDX_W, 8, palette index width
- TRANSP_IDX, 0, palette index treated as transparent

Ports
- vga_clk  in  1  pixel clock; all state on rising edge
- Reset  in  1  synchronous, active-high
- DrawX, DrawY  in  10 each  current pixel coordinate
- SpriteX, SpriteY  in  10 each  top-left corner of sprite box
- blank  in  1  1 = active video (display enabled)
- frame_tick  in  1  one-cycle pulse per video frame (e.g. vsync edge)
- anim_en  in  1  1 = animation advances on frame_tick
- anim_restart  in  1  forces frame 0, hold count 0
- flip  in  1  mirror horizontally (effective only with SPRITE_FLIP_EN)
- rom_addr  out  ADDR_W  combinational address to sync ROM
- rom_q  in  IDX_W  ROM data, valid one rising edge after rom_addr
- pal_idx  out  IDX_W  index to combinational palette (= rom_q)
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_idx
- red, green, blue  out  4 each  registered pixel colour
- sprite_on  out  1  registered: opaque sprite pixel in active video
- frame_idx  out  $clog2(NUM_FRAMES) (min 1)  current animation frame

## Operation
- Hit test uses 11-bit unsigned arithmetic, so there is no overflow at the right or bottom screen edge. Hit = DrawX ≥ SpriteX && DrawX < SpriteX+SPR_W && DrawY ≥ SpriteY && DrawY < SpriteY+SPR_H.
- dx = DrawX−SpriteX, dy = DrawY−SpriteY. With a flip in effect, dx' = SPR_W−1−dx; otherwise dx' = dx.
- rom_addr = frame_idx·SPR_W·SPR_H + dy·SPR_W + dx' when hit; otherwise 0. The value is truncated to ADDR_W.
- Animation counter:
  - hold_cnt is 0..FRAME_HOLD−1.
  - On a frame_tick with anim_en=1: if hold_cnt = FRAME_HOLD−1, hold_cnt→0 and frame_idx→(frame_idx+1) mod NUM_FRAMES. Otherwise hold_cnt increments.
  - With anim_en=0, both counters hold.
- anim_restart is applied the cycle it is high. It overrides a simultaneous frame_tick.
- Output stage:
  - If delayed blank=1, delayed hit=1 and rom_q≠TRANSP_IDX, then red/green/blue = pal_*, sprite_on=1.
  - In every other case, all four outputs = 0.

## Timing
- Stage 0 (cycle t): inputs sampled; rom_addr driven combinationally; hit and blank are registered into stage 1.
- Stage 1 (t+1): rom_q is valid and aligned with hit_d1/blank_d1; the palette resolves combinationally.
- Stage 2: the outputs register at the rising edge ending cycle t+1. Total latency is 2 vga_clk edges, DrawX→RGB.
- Throughput is one pixel per clock with no stalls.
- frame_idx changes at most once per frame_tick. Pixels already in the pipeline finish with the frame they were addressed with.
- Reset clears all pipeline registers, frame_idx, hold_cnt, red/green/blue and sprite_on to 0 on the next edge. The outputs are valid again 2 edges after Reset drops.

## Configuration
- SPRITE_FLIP_EN defined: the flip input mirrors dx as described above.
- SPRITE_FLIP_EN undefined: flip is ignored, dx' = dx, and the mirror subtractor is not built.

## Test plan
- Defaults, SpriteX=100, SpriteY=50, blank=1, sweep DrawX 98..122 on DrawY=50 → rom_addr is 0..19 for DrawX 100..119 and 0 elsewhere. sprite_on rises exactly 2 edges after DrawX=100 for a non-transparent ROM entry.
- ROM entry with index TRANSP_IDX=0 inside the box → RGB=0, sprite_on=0. Index 5 with palette entry F/8/2 → red=F, green=8, blue=2, sprite_on=1. blank=0 forces all outputs to 0.
- SpriteX=630, DrawX 628..639 → no wraparound false hit: hit only for 630..639, and rom_addr dx runs 0..9.
- anim_en=1, FRAME_HOLD=8, 32 frame_ticks → frame_idx steps 0→1→2→3→0, each every 8 ticks. At DrawX=SpriteX, DrawY=SpriteY in frame 2, rom_addr=800.
- anim_restart and frame_tick asserted in the same cycle at frame 3, hold 7 → frame_idx=0, hold_cnt=0. Reset asserted mid-line → outputs are 0 on the next edge.
- With SPRITE_FLIP_EN and flip=1, at DrawX=SpriteX → rom_addr=19 (frame 0). Without the macro, the same stimulus gives rom_addr=0.
